// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S audio blocks: receiver state encoding and
// default geometry. The transmitter side imports the same package.
package i2s_pkg;

    // Receiver framing state: HUNT until the first left-channel boundary,
    // then alternate between the two channel slots.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

    // Default number of bits kept per channel.
    localparam int I2S_W_DATA = 16;

    // Default synchroniser depth for the external I2S pins.
    localparam int I2S_SYNC_STAGES = 2;

    // Width of a counter that must hold the values 0..w inclusive.
    function automatic int i2s_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/i2s_in_sync.sv
// Pin synchroniser for the I2S slave receiver. bclk, lrclk and sdata share
// the same flop depth so they stay mutually aligned after synchronisation;
// a rising edge of the synchronised bclk is reported as a one-clk pulse.
module i2s_in_sync #(
    parameter int sync_stages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bclk,
    input  logic i_lrclk,
    input  logic i_sdata,
    output logic o_lrclk_s,
    output logic o_sdata_s,
    output logic o_bclk_rise
);

    logic [sync_stages-1:0] r_bclk_sync;
    logic [sync_stages-1:0] r_lrclk_sync;
    logic [sync_stages-1:0] r_sdata_sync;
    logic                   r_bclk_d;
    logic                   w_bclk_s;

    // Equal-depth synchroniser chains plus a delayed copy of bclk for edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bclk_sync  <= '0;
            r_lrclk_sync <= '0;
            r_sdata_sync <= '0;
            r_bclk_d     <= 1'b0;
        end else begin
            r_bclk_sync[0]  <= i_bclk;
            r_lrclk_sync[0] <= i_lrclk;
            r_sdata_sync[0] <= i_sdata;
            for (int i = 1; i < sync_stages; i++) begin
                r_bclk_sync[i]  <= r_bclk_sync[i-1];
                r_lrclk_sync[i] <= r_lrclk_sync[i-1];
                r_sdata_sync[i] <= r_sdata_sync[i-1];
            end
            r_bclk_d <= w_bclk_s;
        end
    end

    assign w_bclk_s    = r_bclk_sync[sync_stages-1];
    assign o_lrclk_s   = r_lrclk_sync[sync_stages-1];
    assign o_sdata_s   = r_sdata_sync[sync_stages-1];
    assign o_bclk_rise = w_bclk_s & ~r_bclk_d;

endmodule

// File: rtl/i2s_audio_in.sv
// I2S slave receiver. Captures w_data bits per channel MSB first on rising
// bclk, honouring the one-bclk lrclk lead of standard I2S: the bit sampled
// on the rise where lrclk changes is the LSB slot of the word being closed.
// Longer slots are truncated to their MSBs, shorter ones are left-justified
// and flagged. left/right are published together once per stereo frame.
module i2s_audio_in
    import i2s_pkg::*;
#(
    parameter int w_data      = I2S_W_DATA,
    parameter int sync_stages = I2S_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bclk,
    input  logic              lrclk,
    input  logic              sdata,
    output logic [w_data-1:0] left,
    output logic [w_data-1:0] right,
    output logic              valid,
    output logic              short_word,
    output i2s_state_e        o_state
);

    localparam int                CW       = i2s_cnt_width(w_data);
    localparam logic [CW-1:0]     CNT_FULL = CW'(w_data);
    localparam logic [CW-1:0]     CNT_LAST = CW'(w_data - 1);
    localparam logic [w_data-1:0] MSB_ONE  = {1'b1, {(w_data-1){1'b0}}};

    // Synchronised pins and the rise strobe.
    logic              w_lrclk_s;
    logic              w_sdata_s;
    logic              w_rise;

    // Framing state.
    i2s_state_e        r_state;
    i2s_state_e        w_state_next;

    // Word capture.
    logic              r_ws_prev;
    logic [CW-1:0]     r_bit_cnt;
    logic [w_data-1:0] r_word;
    logic              w_ws_change;
    logic              w_can_shift;
    logic              w_short;
    logic [w_data-1:0] w_word_in;

    // Channel close strobes.
    logic              w_close_left;
    logic              w_close_right;

    // Output registers.
    logic [w_data-1:0] r_left_hold;
    logic [w_data-1:0] r_left;
    logic [w_data-1:0] r_right;
    logic              r_valid;
    logic              r_short;

    i2s_in_sync #(
        .sync_stages (sync_stages)
    ) u_sync (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bclk      (bclk),
        .i_lrclk     (lrclk),
        .i_sdata     (sdata),
        .o_lrclk_s   (w_lrclk_s),
        .o_sdata_s   (w_sdata_s),
        .o_bclk_rise (w_rise)
    );

    // A word boundary is any rise where lrclk differs from the previous rise.
    assign w_ws_change = w_rise & (w_lrclk_s != r_ws_prev);

    // Bits past w_data are dropped; the counter saturates at w_data.
    assign w_can_shift = (r_bit_cnt < CNT_FULL);

    // The word register is filled from the MSB downward, so it is always
    // left-justified; w_word_in is the word including the bit at this rise.
    assign w_word_in = r_word |
                       ((w_can_shift & w_sdata_s) ? (MSB_ONE >> r_bit_cnt) : '0);

    // The closing word holds bit_cnt+1 bits, short when that is below w_data.
    assign w_short = (r_bit_cnt < CNT_LAST);

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: move only on lrclk boundaries; HUNT waits for a 1->0 change.
    always_comb begin
        w_state_next = r_state;
        if (w_ws_change) begin
            case (r_state)
                HUNT:    if (!w_lrclk_s) w_state_next = LEFT;
                LEFT:    if (w_lrclk_s)  w_state_next = RIGHT;
                RIGHT:   if (!w_lrclk_s) w_state_next = LEFT;
                default: w_state_next = HUNT;
            endcase
        end
    end

    // State outputs: which channel word is closing at this boundary.
    always_comb begin
        w_close_left  = 1'b0;
        w_close_right = 1'b0;
        if (w_ws_change) begin
            case (r_state)
                LEFT:    w_close_left  = 1'b1;
                RIGHT:   w_close_right = 1'b1;
                default: ;
            endcase
        end
    end

    // Shift register, bit counter and previous word-select, advanced per rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ws_prev <= 1'b1;
            r_bit_cnt <= '0;
            r_word    <= '0;
        end else if (w_rise) begin
            r_ws_prev <= w_lrclk_s;
            if (w_ws_change) begin
                r_bit_cnt <= '0;
                r_word    <= '0;
            end else if (w_can_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_word    <= w_word_in;
            end
        end
    end

    // Registered outputs: park the left word, publish both on the right close.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left_hold <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_valid     <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            r_valid <= w_close_right;
            r_short <= (w_close_left | w_close_right) & w_short;
            if (w_close_left) begin
                r_left_hold <= w_word_in;
            end
            if (w_close_right) begin
                r_left  <= r_left_hold;
                r_right <= w_word_in;
            end
        end
    end

    assign left       = r_left;
    assign right      = r_right;
    assign valid      = r_valid;
    assign short_word = r_short;
    assign o_state    = r_state;

endmodule

// File: tb/tb_i2s_audio_in.sv
// Bench for the I2S slave receiver. A transmitter task streams channel words
// with the one-bclk lrclk lead; a word-level model turns the driven rise
// sequence into expected frame events, and a forked compare loop checks the
// DUT outputs against them on every clk.
module tb_i2s_audio_in;
    import i2s_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         bclk = 1'b0;
    logic         lrclk = 1'b1;
    logic         sdata = 1'b0;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         valid;
    logic         short_word;
    i2s_state_e   o_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int rise_c   = 0;
    int valid_seen = 0;
    int short_seen = 0;

    // Stream of (word-select, data) pairs, one per bit slot, in send order.
    bit s_ws[$];
    bit s_d[$];

    // Model state: bits of the word in flight and frame bookkeeping.
    bit           m_bits[$];
    bit           m_prev_ws = 1'b1;
    bit           m_locked  = 1'b0;
    logic [W-1:0] m_pend_left = '0;
    logic [W-1:0] m_out_l = '0;
    logic [W-1:0] m_out_r = '0;

    // Expected events: {valid, short, left, right}.
    logic [2*W+1:0] exp_q[$];

    i2s_audio_in #(
        .w_data      (W),
        .sync_stages (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .left       (left),
        .right      (right),
        .valid      (valid),
        .short_word (short_word),
        .o_state    (o_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- model ----------------
    task automatic model_reset();
        m_bits.delete();
        m_prev_ws   = 1'b1;
        m_locked    = 1'b0;
        m_pend_left = '0;
        m_out_l     = '0;
        m_out_r     = '0;
        exp_q.delete();
        s_ws.delete();
        s_d.delete();
    endtask

    // A channel word ended; ch is the word-select it was sent under.
    task automatic model_close(input bit ch);
        logic [W-1:0] val;
        int           n;
        bit           is_short;
        n   = m_bits.size();
        val = '0;
        for (int i = 0; i < n && i < W; i++) val[W-1-i] = m_bits[i];
        is_short = (n < W);
        m_bits.delete();
        if (!m_locked) begin
            if (ch) m_locked = 1'b1;  // first right->left boundary gives frame lock
        end else if (!ch) begin
            m_pend_left = val;
            if (is_short) exp_q.push_back({1'b0, 1'b1, m_out_l, m_out_r});
        end else begin
            m_out_l = m_pend_left;
            m_out_r = val;
            exp_q.push_back({1'b1, is_short, m_out_l, m_out_r});
        end
    endtask

    task automatic model_rise(input bit ws, input bit d);
        m_bits.push_back(d);
        if (ws != m_prev_ws) model_close(m_prev_ws);
        m_prev_ws = ws;
    endtask

    // ---------------- drivers ----------------
    // One bclk period: data/ws change on the fall, sampled at the rise.
    task automatic bclk_cycle(input bit ws, input bit d, input int half);
        bclk  = 1'b0;
        lrclk = ws;
        sdata = d;
        repeat (half) @(negedge clk);
        bclk   = 1'b1;
        rise_c = cyc;
        model_rise(ws, d);
        repeat (half) @(negedge clk);
    endtask

    task automatic push_word(input bit ws, input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            s_ws.push_back(ws);
            s_d.push_back(val[i]);
        end
    endtask

    // Send every queued bit except the last, whose lrclk depends on what follows.
    task automatic flush(input int half);
        while (s_ws.size() > 1) begin
            bclk_cycle(s_ws[1], s_d[0], half);
            void'(s_ws.pop_front());
            void'(s_d.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bclk  = 1'b0;
        model_reset();
        #1;
        chk("rst_left", left, '0);
        chk("rst_right", right, '0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_short", short_word, 1'b0);
        chk("rst_state", o_state, HUNT);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- compare loop ----------------
    task automatic compare_loop();
        logic [W-1:0]   cur_l;
        logic [W-1:0]   cur_r;
        logic           prev_v;
        logic [2*W+1:0] e;
        cur_l  = '0;
        cur_r  = '0;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_l  = '0;
                cur_r  = '0;
                prev_v = 1'b0;
            end else begin
                chk("valid_back_to_back", valid & prev_v, 1'b0);
                if (valid || short_word) begin
                    if (valid) valid_seen++;
                    if (short_word) short_seen++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {valid, short_word}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ev_valid", valid, e[2*W+1]);
                        chk("ev_short", short_word, e[2*W]);
                        cur_l = e[2*W-1:W];
                        cur_r = e[W-1:0];
                    end
                    if (valid) chk("valid_latency", cyc - rise_c, 3);
                end
                chk("left", left, cur_l);
                chk("right", right, cur_r);
                prev_v = valid;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    int v0;
    int s0;

    initial begin
        fork
            compare_loop();
        join_none

        // Scenario 1: 16-bit slots at clk/32, one discarded frame first.
        do_reset();
        v0 = valid_seen;
        s0 = short_seen;
        push_word(1'b1, 32'($urandom_range(0, 16'hFFFF)), 16);
        push_word(1'b0, 32'h0000_A55A, 16);
        push_word(1'b1, 32'h0000_1234, 16);
        push_word(1'b0, 32'h0000_A55A, 16);
        push_word(1'b1, 32'h0000_1234, 16);
        push_word(1'b0, 32'($urandom_range(0, 16'hFFFF)), 16);
        flush(16);
        repeat (8) @(negedge clk);
        chk("s1_valid_count", valid_seen - v0, 2);
        chk("s1_short_count", short_seen - s0, 0);
        chk("s1_left", left, 16'hA55A);
        chk("s1_right", right, 16'h1234);
        chk("s1_state", o_state, LEFT);

        // Scenario 2: 32-bit slots, only the MSBs are kept.
        v0 = valid_seen;
        push_word(1'b1, {16'h7FFE, 16'($urandom)}, 32);
        push_word(1'b0, {16'h8001, 16'($urandom)}, 32);
        push_word(1'b1, {16'h7FFE, 16'($urandom)}, 32);
        push_word(1'b0, 32'($urandom), 32);
        flush(4);
        repeat (8) @(negedge clk);
        chk("s2_valid_count", valid_seen - v0, 2);
        chk("s2_left", left, 16'h8001);
        chk("s2_right", right, 16'h7FFE);

        // Scenario 3: 12-bit right word is left-justified and flagged.
        v0 = valid_seen;
        s0 = short_seen;
        push_word(1'b1, 32'($urandom_range(0, 16'hFFFF)), 16);
        push_word(1'b0, 32'($urandom_range(0, 16'hFFFF)), 16);
        push_word(1'b1, 32'h0000_0ABC, 12);
        push_word(1'b0, 32'($urandom_range(0, 16'hFFFF)), 16);
        flush(4);
        repeat (8) @(negedge clk);
        chk("s3_valid_count", valid_seen - v0, 2);
        chk("s3_short_count", short_seen - s0, 1);
        chk("s3_right", right, 16'hABC0);

        // Scenario 4: reset in the middle of a right word.
        push_word(1'b1, 32'($urandom_range(0, 16'hFFFF)), 16);
        flush(4);
        chk("s4_drained", exp_q.size(), 0);
        do_reset();
        v0 = valid_seen;
        push_word(1'b1, 32'($urandom_range(0, 16'hFFFF)), 16);
        push_word(1'b0, 32'h0000_1357, 16);
        push_word(1'b1, 32'h0000_2468, 16);
        push_word(1'b0, 32'($urandom_range(0, 16'hFFFF)), 16);
        flush(4);
        repeat (8) @(negedge clk);
        chk("s4_valid_count", valid_seen - v0, 1);
        chk("s4_left", left, 16'h1357);
        chk("s4_right", right, 16'h2468);
        chk("s4_drained_end", exp_q.size(), 0);

        // Scenario 5: lrclk stuck high never leaves HUNT.
        do_reset();
        v0 = valid_seen;
        for (int i = 0; i < 100; i++) bclk_cycle(1'b1, 1'($urandom_range(0, 1)), 2);
        repeat (8) @(negedge clk);
        chk("s5_state", o_state, HUNT);
        chk("s5_valid_count", valid_seen - v0, 0);
        chk("s5_left", left, '0);

        // Scenario 6: fastest bclk (clk/4) with alternating data.
        v0 = valid_seen;
        for (int i = 0; i < 6; i++) push_word(i[0] ? 1'b0 : 1'b1, 32'h0000_AAAA, 16);
        flush(2);
        repeat (8) @(negedge clk);
        chk("s6_valid_count", valid_seen - v0, 2);
        chk("s6_left", left, 16'hAAAA);
        chk("s6_right", right, 16'hAAAA);
        chk("s6_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_audio_in.md
I2S_AUDIO_IN -- requirements
Module: i2s_audio_in

Interface
REQ-001 The module SHALL have parameter w_data, default 16, meaning the number of bits captured per channel, MSB first.
REQ-002 The module SHALL have parameter sync_stages, default 2, meaning the synchroniser depth applied to every external I2S input.
REQ-003 The module SHALL have port clk, input, 1 bit: the system clock (100 MHz on current boards); all logic is in this single clock domain.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port bclk, input, 1 bit: external I2S bit clock (this block is the clock slave).
REQ-006 The module SHALL have port lrclk, input, 1 bit: external word select; 0 = left, 1 = right.
REQ-007 The module SHALL have port sdata, input, 1 bit: serial data, driven by the transmitter on falling bclk.
REQ-008 The module SHALL have port left, output, w_data bits: the last complete left sample.
REQ-009 The module SHALL have port right, output, w_data bits: the last complete right sample.
REQ-010 The module SHALL have port valid, output, 1 bit: a one-clk pulse asserted when left and right update together.
REQ-011 The module SHALL have port short_word, output, 1 bit: a one-clk pulse when a closed channel word carried fewer than w_data bits.

Function
REQ-012 bclk, lrclk and sdata SHALL each pass through sync_stages flops of equal depth, so the three stay mutually aligned.
REQ-013 A bclk rise event SHALL be detected when the synchronised bclk is 1 and its one-cycle-delayed copy is 0.
REQ-014 Correct operation SHALL be guaranteed for bclk frequency ≤ clk/4; behaviour above that limit is undefined.
REQ-015 On every rise event, lrclk_s SHALL be compared with ws_prev, a register updated at every rise event.
REQ-016 On a rise event with no lrclk change, sdata_s SHALL be shifted in, MSB first, if bit_cnt < w_data, and bit_cnt SHALL then increment.
- bit_cnt saturates at w_data.
- Bits beyond w_data are ignored, so 24- and 32-bit slots are truncated to their MSBs.
REQ-017 On a rise event with an lrclk change, the bit sampled at that rise SHALL be treated as the last bit (LSB slot) of the closing word and shifted in if bit_cnt < w_data.
- The word then closes.
- The shift register and bit_cnt then clear for the new channel.
- This reflects the standard I2S one-bclk delay.
REQ-018 A closing word SHALL be left-justified: if it has fewer than w_data bits, the missing LSBs are zero and short_word pulses.
REQ-019 The state machine SHALL have states HUNT, LEFT and RIGHT.
- HUNT to LEFT: first lrclk 1→0 change after reset. The partial word is discarded, with no short_word.
- LEFT to RIGHT: lrclk 0→1. The closed word is stored in left_hold.
- RIGHT to LEFT: lrclk 1→0. left ← left_hold, right ← the closed word, valid pulses.
- HUNT ignores a 0→1 change.
REQ-020 left, right, valid and short_word SHALL be registered and SHALL update on the clk edge following the cycle in which the rise event is detected.
REQ-021 With sync_stages = 2, valid SHALL rise on the 3rd clk edge after the first clk edge that samples the bclk pin high.
REQ-022 valid SHALL never be asserted for two consecutive cycles.

Reset
REQ-023 While rst_n = 0, the following SHALL hold:
- state = HUNT.
- left = right = left_hold = 0.
- valid = short_word = 0.
- bit_cnt = 0, the shift register = 0, ws_prev = 1.
- All synchroniser flops = 0.
REQ-024 Reset asserted mid-word SHALL immediately abort capture, and the first valid after release SHALL require a full HUNT→LEFT→RIGHT→LEFT sequence.

Structure
REQ-025 Package i2s_pkg SHALL hold the state enum (HUNT, LEFT, RIGHT) and the default w_data constant; i2s_audio_out SHALL be able to import it.
REQ-026 One sub-module, i2s_in_sync, SHALL implement the synchroniser plus bclk rise detection; all remaining logic stays in i2s_audio_in.

Verification
REQ-027 Scenario 1 — 16-bit slots at bclk = clk/32, left = 16'hA55A, right = 16'h1234, sent after one discarded frame. Required response: valid pulses once per frame, left = A55A, right = 1234, short_word = 0.
REQ-028 Scenario 2 — 32-bit slots, left MSBs = 16'h8001, right MSBs = 16'h7FFE, low bits random. Required response: left = 8001, right = 7FFE.
REQ-029 Scenario 3 — 12-bit right word 12'hABC. Required response: short_word pulses, right = 16'hABC0.
REQ-030 Scenario 4 — rst_n pulsed low mid right word. Required response: all outputs 0 at once, and no valid until one full discarded frame has passed.
REQ-031 Scenario 5 — lrclk held at 1 from reset for 100 bclk. Required response: state remains HUNT, valid = 0.
REQ-032 Scenario 6 — bclk = clk/4 with sdata alternating 1/0. Required response: left = right = 16'hAAAA; measured latency matches REQ-021.
